// File: rtl/picosoc_iomem_timer.sv
// Prescaled 32-bit countdown timer with auto-reload, sticky expiry flag and a
// level IRQ, answering PicoSoC iomem accesses with exactly one wait state.
module picosoc_iomem_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq
);
  localparam int unsigned DW  = 32;
  localparam int unsigned PW  = 16;
  localparam int unsigned CW  = 3;
  localparam int unsigned SW  = 6;
  localparam int unsigned NB  = DW / 8;
  localparam int unsigned NPB = PW / 8;

  localparam logic [SW-1:0] A_CTRL     = 6'h00;
  localparam logic [SW-1:0] A_PRESCALE = 6'h01;
  localparam logic [SW-1:0] A_RELOAD   = 6'h02;
  localparam logic [SW-1:0] A_COUNT    = 6'h03;
  localparam logic [SW-1:0] A_STATUS   = 6'h04;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACK = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic            w_hit, w_accept, w_ready, w_wr, w_tick, w_expire;
  logic            w_wr_ctrl, w_wr_prescale, w_wr_reload, w_wr_count, w_wr_status;
  logic [SW-1:0]   w_sel;
  logic [CW-1:0]   r_ctrl, w_ctrl_nxt;
  logic [PW-1:0]   r_prescale, w_prescale_nxt, r_pcnt, w_pcnt_nxt;
  logic [DW-1:0]   r_reload, w_reload_nxt, r_count, w_count_nxt;
  logic [DW-1:0]   r_rdata, w_rdata;
  logic            r_exp, w_exp_nxt;
  logic            w_unused;

  assign w_hit    = (iomem_addr[31:8] == BASE_ADDR[31:8]);
  assign w_sel    = iomem_addr[7:2];
  assign w_unused = ^iomem_addr[1:0];

  // Bus FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (iomem_valid && w_hit && !iomem_ready) w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready  = 1'b0;
    w_accept = 1'b0;
    if (r_state == S_ACK) w_ready = 1'b1;
    if (r_state == S_IDLE && iomem_valid && w_hit) w_accept = 1'b1;
  end

  assign w_wr          = w_accept && (iomem_wstrb != 4'b0000);
  assign w_wr_ctrl     = w_wr && (w_sel == A_CTRL);
  assign w_wr_prescale = w_wr && (w_sel == A_PRESCALE);
  assign w_wr_reload   = w_wr && (w_sel == A_RELOAD);
  assign w_wr_count    = w_wr && (w_sel == A_COUNT);
  assign w_wr_status   = w_wr && (w_sel == A_STATUS);

  assign w_tick   = r_ctrl[0] && (r_pcnt == r_prescale);
  assign w_expire = w_tick && !w_wr_count && (r_count == '0);

  // Register next-state: tick effects first, bus writes override, expiry beats W1C
  always_comb begin
    w_ctrl_nxt     = r_ctrl;
    w_prescale_nxt = r_prescale;
    w_reload_nxt   = r_reload;
    w_count_nxt    = r_count;
    w_exp_nxt      = r_exp;
    w_pcnt_nxt     = r_pcnt;
    if (w_tick && !w_wr_count) begin
      if (r_count != '0)  w_count_nxt   = r_count - DW'(1);
      else if (r_ctrl[1]) w_count_nxt   = r_reload;
      else                w_ctrl_nxt[0] = 1'b0;
    end
    if (w_wr_ctrl && iomem_wstrb[0]) w_ctrl_nxt = iomem_wdata[CW-1:0];
    for (int unsigned b = 0; b < NB; b++) begin
      if (iomem_wstrb[b] && w_wr_reload) w_reload_nxt[8*b +: 8] = iomem_wdata[8*b +: 8];
      if (iomem_wstrb[b] && w_wr_count)  w_count_nxt[8*b +: 8]  = iomem_wdata[8*b +: 8];
    end
    for (int unsigned b = 0; b < NPB; b++) begin
      if (iomem_wstrb[b] && w_wr_prescale) w_prescale_nxt[8*b +: 8] = iomem_wdata[8*b +: 8];
    end
    if (w_wr_status && iomem_wstrb[0] && iomem_wdata[0]) w_exp_nxt = 1'b0;
    if (w_expire) w_exp_nxt = 1'b1;
    if (!r_ctrl[0] || !w_ctrl_nxt[0] || w_tick) w_pcnt_nxt = '0;
    else                                        w_pcnt_nxt = r_pcnt + PW'(1);
  end

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      A_CTRL:     w_rdata = DW'(r_ctrl);
      A_PRESCALE: w_rdata = DW'(r_prescale);
      A_RELOAD:   w_rdata = r_reload;
      A_COUNT:    w_rdata = r_count;
      A_STATUS:   w_rdata = DW'(r_exp);
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ctrl     <= '0;
      r_prescale <= '0;
      r_reload   <= '0;
      r_count    <= '0;
      r_exp      <= 1'b0;
      r_pcnt     <= '0;
      r_rdata    <= '0;
    end else begin
      r_ctrl     <= w_ctrl_nxt;
      r_prescale <= w_prescale_nxt;
      r_reload   <= w_reload_nxt;
      r_count    <= w_count_nxt;
      r_exp      <= w_exp_nxt;
      r_pcnt     <= w_pcnt_nxt;
      if (w_accept) r_rdata <= w_rdata;
    end
  end

  assign iomem_ready = w_ready;
  assign iomem_rdata = r_rdata;
  assign irq         = r_exp & r_ctrl[2];

endmodule

// File: tb/tb_picosoc_iomem_timer.sv
// Self-checking bench for picosoc_iomem_timer: vector table, directed timing
// sequences and randomized runs against an arithmetic reference model.
module tb_picosoc_iomem_timer;
  localparam logic [31:0] BASE = 32'h0300_0000;
  localparam logic [7:0] O_CTRL = 8'h00, O_PRE = 8'h04, O_REL = 8'h08, O_CNT = 8'h0C, O_ST = 8'h10;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [31:0] iomem_addr = 32'h0;
  logic [31:0] iomem_wdata = 32'h0;
  logic [31:0] iomem_rdata;
  logic        irq;

  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    logic [7:0]  off;
    logic [3:0]  ws;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [22];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  picosoc_iomem_timer #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .resetn(resetn), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata), .irq(irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int unsigned n);
    if (n == 0) return;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [7:0] off, input logic [3:0] ws, input logic [31:0] wd,
                     output logic [31:0] rd, output int unsigned cap, output logic irq_s);
    int lat;
    lat = 0;
    iomem_valid = 1'b1;
    iomem_addr  = BASE + 32'(off);
    iomem_wstrb = ws;
    iomem_wdata = wd;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!iomem_ready && lat < 8);
    chk("latency", 32'(lat), 32'd1);
    rd    = iomem_rdata;
    irq_s = irq;
    cap   = cyc;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    @(posedge clk); #1;
    chk("ready_pulse_width", 32'(iomem_ready), 32'd0);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] wd);
    logic [31:0] rd; int unsigned cap; logic irs;
    bus(off, 4'hF, wd, rd, cap, irs);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] rd; int unsigned cap; logic irs;
    bus(off, 4'h0, 32'h0, rd, cap, irs);
    chk(name, rd, exp);
  endtask

  // State after edge ed for a timer enabled on edge e, computed from tick counts.
  function automatic void model(input int unsigned c, input int unsigned r, input int unsigned p,
                                input bit ar, input int unsigned e, input int unsigned ed,
                                output int unsigned cnt, output bit xp, output bit en);
    int unsigned n;
    n = (ed - e) / (p + 1);
    if (n <= c) begin
      cnt = c - n; xp = 1'b0; en = 1'b1;
    end else if (!ar) begin
      cnt = 0; xp = 1'b1; en = 1'b0;
    end else begin
      cnt = r - ((n - c - 1) % (r + 1)); xp = 1'b1; en = 1'b1;
    end
  endfunction

  initial begin
    logic [31:0] rd, expv;
    logic        irs;
    int unsigned cap, e, t, p, r, c, cnt, sel;
    bit          ar, ie, xp, en;

    tbl[0]  = '{O_CTRL, 4'h0, 32'h0,         1'b1, 32'h0};
    tbl[1]  = '{O_PRE,  4'h0, 32'h0,         1'b1, 32'h0};
    tbl[2]  = '{O_REL,  4'h0, 32'h0,         1'b1, 32'h0};
    tbl[3]  = '{O_CNT,  4'h0, 32'h0,         1'b1, 32'h0};
    tbl[4]  = '{O_ST,   4'h0, 32'h0,         1'b1, 32'h0};
    tbl[5]  = '{8'h14,  4'h0, 32'h0,         1'b1, 32'h0};
    tbl[6]  = '{O_REL,  4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0};
    tbl[7]  = '{O_REL,  4'h2, 32'h1234_5678, 1'b0, 32'h0};
    tbl[8]  = '{O_REL,  4'h0, 32'h0,         1'b1, 32'hFFFF_56FF};
    tbl[9]  = '{8'h0B,  4'h0, 32'h0,         1'b1, 32'hFFFF_56FF};
    tbl[10] = '{O_PRE,  4'hF, 32'hABCD_1234, 1'b0, 32'h0};
    tbl[11] = '{O_PRE,  4'h0, 32'h0,         1'b1, 32'h0000_1234};
    tbl[12] = '{O_CNT,  4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0};
    tbl[13] = '{O_CNT,  4'h0, 32'h0,         1'b1, 32'hDEAD_BEEF};
    tbl[14] = '{8'h20,  4'hF, 32'h0000_0055, 1'b0, 32'h0};
    tbl[15] = '{8'h20,  4'h0, 32'h0,         1'b1, 32'h0};
    tbl[16] = '{O_CTRL, 4'h1, 32'hFFFF_FF06, 1'b0, 32'h0};
    tbl[17] = '{O_CTRL, 4'h0, 32'h0,         1'b1, 32'h6};
    tbl[18] = '{O_CTRL, 4'h2, 32'hFFFF_FFFF, 1'b0, 32'h0};
    tbl[19] = '{O_CTRL, 4'h0, 32'h0,         1'b1, 32'h6};
    tbl[20] = '{O_CTRL, 4'hF, 32'h0,         1'b0, 32'h0};
    tbl[21] = '{O_CTRL, 4'h0, 32'h0,         1'b1, 32'h0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 32'(iomem_ready), 32'd0);
    chk("reset_rdata", iomem_rdata, 32'h0);
    chk("reset_irq", 32'(irq), 32'd0);
    resetn = 1'b1;
    idle(1);

    for (int i = 0; i < 22; i++) begin
      bus(tbl[i].off, tbl[i].ws, tbl[i].wd, rd, cap, irs);
      if (tbl[i].chk) chk($sformatf("vec%0d", i), rd, tbl[i].exp);
    end

    // Auto-reload period: PRESCALE=3, RELOAD=4, COUNT=4 -> irq every 20 cycles
    wr(O_ST, 32'h1); wr(O_PRE, 32'd3); wr(O_REL, 32'd4); wr(O_CNT, 32'd4);
    bus(O_CTRL, 4'hF, 32'h7, rd, e, irs);
    t = 0;
    while (!irq && t < 60) begin @(posedge clk); #1; t++; end
    chk("irq_first_rise_cycle", cyc, e + 20);
    bus(O_ST, 4'hF, 32'h1, rd, cap, irs);
    chk("irq_drop_after_w1c", 32'(irs), 32'd0);
    t = 0;
    while (!irq && t < 60) begin @(posedge clk); #1; t++; end
    chk("irq_second_rise_cycle", cyc, e + 40);

    // One-shot: PRESCALE=0, COUNT=2 -> EXP 3 cycles after enable, EN self-clears
    wr(O_CTRL, 32'h0); wr(O_ST, 32'h1); wr(O_PRE, 32'd0); wr(O_CNT, 32'd2);
    wr(O_CTRL, 32'h1);
    rd_chk("oneshot_exp_before", O_ST, 32'h0);
    rd_chk("oneshot_exp_after", O_ST, 32'h1);
    rd_chk("oneshot_en_cleared", O_CTRL, 32'h0);
    rd_chk("oneshot_count_zero", O_CNT, 32'h0);
    chk("oneshot_irq_masked", 32'(irq), 32'd0);

    // W1C landing on the expiry edge: set wins
    wr(O_CTRL, 32'h0); wr(O_ST, 32'h1); wr(O_PRE, 32'd0); wr(O_REL, 32'd9); wr(O_CNT, 32'd9);
    bus(O_CTRL, 4'hF, 32'h3, rd, e, irs);
    idle(e + 9 - cyc);
    bus(O_ST, 4'hF, 32'h1, rd, cap, irs);
    chk("w1c_on_expiry_edge", cap, e + 10);
    rd_chk("exp_set_beats_w1c", O_ST, 32'h1);
    wr(O_ST, 32'h1);
    rd_chk("exp_cleared_by_w1c", O_ST, 32'h0);

    // COUNT write on a tick edge: write wins, no decrement
    wr(O_CTRL, 32'h0); wr(O_PRE, 32'd7); wr(O_REL, 32'd0); wr(O_CNT, 32'd100);
    bus(O_CTRL, 4'hF, 32'h3, rd, e, irs);
    idle(e + 15 - cyc);
    bus(O_CNT, 4'hF, 32'd9, rd, cap, irs);
    chk("count_write_tick_edge", cap, e + 16);
    rd_chk("count_write_wins", O_CNT, 32'd9);
    idle(e + 24 - cyc);
    rd_chk("count_after_next_tick", O_CNT, 32'd8);

    // Randomized runs against the tick-count model
    for (int k = 0; k < 16; k++) begin
      p = $urandom_range(0, 3); r = $urandom_range(0, 6); c = $urandom_range(0, 6);
      ar = 1'($urandom); ie = 1'($urandom);
      wr(O_CTRL, 32'h0); wr(O_ST, 32'h1); wr(O_PRE, p); wr(O_REL, r); wr(O_CNT, c);
      bus(O_CTRL, 4'hF, {29'b0, ie, ar, 1'b1}, rd, e, irs);
      for (int j = 0; j < 4; j++) begin
        idle($urandom_range(0, 12));
        sel = $urandom_range(0, 2);
        bus((sel == 0) ? O_CTRL : (sel == 1) ? O_CNT : O_ST, 4'h0, 32'h0, rd, cap, irs);
        model(c, r, p, ar, e, cap - 1, cnt, xp, en);
        expv = (sel == 0) ? {29'b0, ie, ar, en} : (sel == 1) ? cnt : {31'b0, xp};
        chk($sformatf("rand%0d_%0d_sel%0d", k, j, sel), rd, expv);
        model(c, r, p, ar, e, cap, cnt, xp, en);
        chk($sformatf("rand%0d_%0d_irq", k, j), 32'(irs), 32'(xp & ie));
      end
    end

    // Address outside the window: no response, no register change
    wr(O_CTRL, 32'h0); wr(O_ST, 32'h1); wr(O_REL, 32'h0000_1111);
    iomem_valid = 1'b1; iomem_addr = 32'h0400_0008; iomem_wstrb = 4'hF; iomem_wdata = 32'hAAAA_AAAA;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("miss_no_ready", 32'(iomem_ready), 32'd0);
    end
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    idle(1);
    rd_chk("miss_reload_unchanged", O_REL, 32'h0000_1111);
    rd_chk("miss_ctrl_unchanged", O_CTRL, 32'h0);

    // Reset asserted while in ACK
    wr(O_PRE, 32'd5); wr(O_REL, 32'd7); wr(O_CNT, 32'd3); wr(O_CTRL, 32'h7);
    iomem_valid = 1'b1; iomem_addr = BASE + 32'(O_REL); iomem_wstrb = 4'hF; iomem_wdata = 32'hABCD;
    @(posedge clk); #1;
    chk("ack_before_reset", 32'(iomem_ready), 32'd1);
    resetn = 1'b0;
    #1;
    chk("ready_async_drop", 32'(iomem_ready), 32'd0);
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
    idle(1);
    rd_chk("post_reset_ctrl", O_CTRL, 32'h0);
    rd_chk("post_reset_prescale", O_PRE, 32'h0);
    rd_chk("post_reset_reload", O_REL, 32'h0);
    rd_chk("post_reset_count", O_CNT, 32'h0);
    rd_chk("post_reset_status", O_ST, 32'h0);
    chk("post_reset_irq", 32'(irq), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

endmodule
